// File: rtl/very_simple_cpu.sv
// Memory-to-memory 32-bit CPU: FETCH, LD_IW, LD_A, EXEC (+IND for CPI) over one sync RAM port.
// 4 clocks per instruction, 5 for CPI; no backpressure, RAM answers every cycle.
module very_simple_cpu #(
  parameter int W_ADDR = 14,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              wrEn,
  output logic [W_ADDR-1:0] addr_toRAM,
  output logic [W_DATA-1:0] data_toRAM,
  input  logic [W_DATA-1:0] data_fromRAM
);

  localparam int C_SHW = $clog2(W_DATA);
  localparam logic [W_DATA-1:0] C_WD = W_DATA;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LD_IW,
    S_LD_A,
    S_EXEC,
    S_IND
  } state_t;

  state_t            r_state;
  logic [W_ADDR-1:0] r_pc;
  logic [W_DATA-1:0] r_iw;
  logic [W_DATA-1:0] r_r1;

  logic [2:0]        w_op;
  logic              w_i;
  logic [W_ADDR-1:0] w_a_fld;
  logic [W_ADDR-1:0] w_b_fld;
  logic [W_DATA-1:0] w_b_ext;
  logic [W_DATA-1:0] w_b;
  logic [W_DATA-1:0] w_sh_left;
  logic [W_DATA-1:0] w_alu;
  logic [W_DATA-1:0] w_jmp_sum;
  logic [W_ADDR-1:0] w_pc_inc;
  logic [W_ADDR-1:0] w_pc_next;

  assign w_op      = r_iw[W_DATA-1 -: 3];
  assign w_i       = r_iw[W_DATA-4];
  assign w_a_fld   = r_iw[2*W_ADDR-1 -: W_ADDR];
  assign w_b_fld   = r_iw[W_ADDR-1:0];
  assign w_b_ext   = {{(W_DATA-W_ADDR){1'b0}}, w_b_fld};
  // In EXEC the RAM is returning *B, so the register form of b comes straight off the bus.
  assign w_b       = w_i ? w_b_ext : data_fromRAM;
  assign w_sh_left = w_b - C_WD;
  assign w_jmp_sum = r_r1 + w_b_ext;
  assign w_pc_inc  = r_pc + W_ADDR'(1);

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_r1 + w_b;
      OP_NAND: w_alu = ~(r_r1 & w_b);
      OP_SRL: begin
        if (w_b < C_WD)           w_alu = r_r1 >> w_b[C_SHW-1:0];
        else if (w_sh_left < C_WD) w_alu = r_r1 << w_sh_left[C_SHW-1:0];
        else                      w_alu = '0;
      end
      OP_LT:   w_alu = {{(W_DATA-1){1'b0}}, (r_r1 < w_b)};
      OP_CP:   w_alu = w_b;
      OP_MUL:  w_alu = r_r1 * w_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_op == OP_BZJ) begin
      if (w_i)                    w_pc_next = w_jmp_sum[W_ADDR-1:0];
      else if (data_fromRAM == '0) w_pc_next = r_r1[W_ADDR-1:0];
    end
  end

  always_comb begin
    wrEn       = 1'b0;
    addr_toRAM = r_pc;
    data_toRAM = '0;
    case (r_state)
      S_FETCH: addr_toRAM = r_pc;
      S_LD_IW: addr_toRAM = data_fromRAM[2*W_ADDR-1 -: W_ADDR];
      S_LD_A:  addr_toRAM = w_b_fld;
      S_EXEC: begin
        case (w_op)
          OP_BZJ: addr_toRAM = w_a_fld;
          OP_CPI: begin
            if (!w_i) begin
              addr_toRAM = data_fromRAM[W_ADDR-1:0];
            end else begin
              wrEn       = 1'b1;
              addr_toRAM = r_r1[W_ADDR-1:0];
              data_toRAM = data_fromRAM;
            end
          end
          default: begin
            wrEn       = 1'b1;
            addr_toRAM = w_a_fld;
            data_toRAM = w_alu;
          end
        endcase
      end
      S_IND: begin
        wrEn       = 1'b1;
        addr_toRAM = w_a_fld;
        data_toRAM = data_fromRAM;
      end
      default: addr_toRAM = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_iw    <= '0;
      r_r1    <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_LD_IW;
        S_LD_IW: begin
          r_iw    <= data_fromRAM;
          r_state <= S_LD_A;
        end
        S_LD_A: begin
          r_r1    <= data_fromRAM;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_op == OP_CPI && !w_i) begin
            r_state <= S_IND;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        S_IND: begin
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_very_simple_cpu.sv
// Bench for very_simple_cpu: sync RAM model plus an instruction-level reference model.
module tb_very_simple_cpu;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrEn;
  logic [AW-1:0] addr_toRAM;
  logic [DW-1:0] data_toRAM;
  logic [DW-1:0] data_fromRAM;

  logic          clr   = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_a  = '0;
  logic [DW-1:0] ld_d  = '0;

  logic [DW-1:0] ram [MSZ];
  logic [DW-1:0] mdl [MSZ];
  logic [AW-1:0] mpc;

  int errors = 0;
  int checks = 0;

  very_simple_cpu #(.W_ADDR(AW), .W_DATA(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .data_fromRAM (data_fromRAM)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < MSZ; k++) ram[k] <= '0;
    end else if (ld_en) begin
      ram[ld_a] <= ld_d;
    end else if (wrEn) begin
      ram[addr_toRAM] <= data_toRAM;
    end
    data_fromRAM <= ram[addr_toRAM];
  end

  function automatic logic [31:0] enc(int op, int i, int a, int b);
    return {op[2:0], i[0], a[13:0], b[13:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset, wipe both memories, and check the reset-state outputs.
  task automatic start_test();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wrEn", 32'(wrEn), 0);
    chk("rst_addr", 32'(addr_toRAM), 0);
    chk("rst_data", data_toRAM, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < MSZ; k++) mdl[k] = '0;
    mpc = '0;
  endtask

  task automatic poke(int a, logic [31:0] d);
    mdl[a] = d;
    ld_en  = 1'b1;
    ld_a   = a[AW-1:0];
    ld_d   = d;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  task automatic go();
    rst = 1'b1;
  endtask

  // Executes one instruction in the model and checks the DUT cycle by cycle.
  // Entered and left at a falling edge with the DUT in FETCH.
  task automatic run_instr(string tag);
    logic [31:0] iw, a, vb, b, wd;
    logic [2:0]  op;
    logic        i, wr, cpi;
    logic [13:0] fa, fb, wa, npc;
    iw  = mdl[mpc];
    op  = iw[31:29];
    i   = iw[28];
    fa  = iw[27:14];
    fb  = iw[13:0];
    a   = mdl[fa];
    vb  = mdl[fb];
    b   = i ? 32'(fb) : vb;
    wr  = 1'b1;
    cpi = 1'b0;
    wa  = fa;
    wd  = '0;
    npc = mpc + 14'd1;
    case (op)
      3'd0: wd = a + b;
      3'd1: wd = ~(a & b);
      3'd2: wd = (b < 32) ? (a >> b) : (a << (b - 32));
      3'd3: wd = (a < b) ? 32'd1 : 32'd0;
      3'd4: wd = b;
      3'd5: begin
        if (!i) begin
          cpi = 1'b1;
          wd  = mdl[vb[13:0]];
        end else begin
          wa = a[13:0];
          wd = vb;
        end
      end
      3'd6: begin
        wr = 1'b0;
        if (i)            npc = 14'(a + 32'(fb));
        else if (vb == 0) npc = a[13:0];
      end
      default: wd = a * b;
    endcase

    chk({tag, ":fetch_addr"}, 32'(addr_toRAM), 32'(mpc));
    chk({tag, ":fetch_wrEn"}, 32'(wrEn), 0);
    @(negedge clk);
    chk({tag, ":ldiw_addr"}, 32'(addr_toRAM), 32'(fa));
    chk({tag, ":ldiw_wrEn"}, 32'(wrEn), 0);
    @(negedge clk);
    chk({tag, ":lda_addr"}, 32'(addr_toRAM), 32'(fb));
    chk({tag, ":lda_wrEn"}, 32'(wrEn), 0);
    @(negedge clk);
    if (cpi) begin
      chk({tag, ":cpi_exec_wrEn"}, 32'(wrEn), 0);
      chk({tag, ":cpi_exec_addr"}, 32'(addr_toRAM), 32'(vb[13:0]));
      @(negedge clk);
    end
    chk({tag, ":exec_wrEn"}, 32'(wrEn), 32'(wr));
    if (wr) begin
      chk({tag, ":wr_addr"}, 32'(addr_toRAM), 32'(wa));
      chk({tag, ":wr_data"}, data_toRAM, wd);
      mdl[wa] = wd;
    end
    mpc = npc;
    @(negedge clk);
  endtask

  initial begin
    int diffs;
    logic [31:0] w;

    // CP register and immediate forms
    start_test();
    poke(0, 32'h806401F4);
    poke(1, enc(4, 1, 401, 7));
    poke(500, 10);
    go();
    run_instr("cp");
    chk("cp_mem400", ram[400], 10);
    run_instr("cpi_imm");
    chk("cpimm_mem401", ram[401], 7);

    // ALU operations
    start_test();
    poke(0, enc(0, 1, 100, 1));
    poke(1, enc(7, 0, 101, 102));
    poke(2, enc(3, 0, 103, 104));
    poke(3, enc(3, 0, 105, 106));
    poke(4, enc(1, 1, 107, 'hFF));
    poke(5, enc(2, 1, 108, 4));
    poke(6, enc(2, 1, 109, 33));
    poke(100, 32'hFFFF_FFFF);
    poke(101, 6);   poke(102, 11);
    poke(103, 5);   poke(104, 7);
    poke(105, 7);   poke(106, 5);
    poke(107, 'hF0);
    poke(108, 'h80);
    poke(109, 1);
    go();
    for (int k = 0; k < 7; k++) run_instr("alu");
    chk("addi_wrap", ram[100], 0);
    chk("mul", ram[101], 66);
    chk("lt_true", ram[103], 1);
    chk("lt_false", ram[105], 0);
    chk("nandi", ram[107], 32'hFFFF_FF0F);
    chk("srli_right", ram[108], 8);
    chk("srli_left", ram[109], 2);

    // Indirect copies
    start_test();
    poke(0, enc(5, 0, 110, 111));
    poke(1, enc(5, 1, 112, 113));
    poke(111, 301); poke(301, 6);
    poke(112, 200); poke(113, 9);
    go();
    run_instr("cpi");
    chk("cpi_mem110", ram[110], 6);
    run_instr("cpii");
    chk("cpii_mem200", ram[200], 9);

    // Branches
    start_test();
    poke(0, enc(6, 0, 120, 121));
    poke(11, enc(6, 0, 120, 122));
    poke(12, enc(6, 1, 123, 2));
    poke(120, 11); poke(121, 0); poke(122, 1); poke(123, 3);
    go();
    run_instr("bzj_taken");
    chk("bzj_taken_pc", 32'(addr_toRAM), 11);
    run_instr("bzj_not");
    chk("bzj_not_pc", 32'(addr_toRAM), 12);
    run_instr("bzji");
    chk("bzji_pc", 32'(addr_toRAM), 5);

    // Reset during the write cycle of an ADD
    start_test();
    poke(0, enc(0, 1, 130, 5));
    poke(130, 100);
    go();
    repeat (3) @(negedge clk);
    chk("midrst_pre_wrEn", 32'(wrEn), 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_wrEn", 32'(wrEn), 0);
    chk("midrst_addr", 32'(addr_toRAM), 0);
    chk("midrst_data", data_toRAM, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_nowrite", ram[130], 100);
    rst = 1'b1;
    run_instr("after_rst");
    chk("after_rst_mem", ram[130], 105);

    // Random programs in a small window of memory
    for (int t = 0; t < 6; t++) begin
      start_test();
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 3) == 0) w = $urandom;
        else w = enc($urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 63), $urandom_range(0, 63));
        poke(k, w);
      end
      go();
      repeat (40) run_instr("rnd");
      diffs = 0;
      for (int k = 0; k < MSZ; k++) if (ram[k] !== mdl[k]) diffs++;
      chk("rnd_mem_diffs", diffs, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/very_simple_cpu.md
# very_simple_cpu

Multi-cycle, memory-to-memory 32-bit processor with 8 opcodes, each with a register-free and an immediate form. Every operand lives in an external single-port synchronous RAM with a 14-bit word address. The RAM returns read data one clock after the address and writes when `wrEn` is high. The CPU holds only a PC, an instruction register and operand latches, and sequences fetch, operand reads, execute and write-back through a small FSM.

## Interface
- `W_ADDR`, 14: word address width; also the width of fields A and B.
- `W_DATA`, 32: data and instruction width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wrEn` out 1: RAM write enable for the current cycle.
- `addr_toRAM` out 14: RAM address.
- `data_toRAM` out 32: RAM write data.
- `data_fromRAM` in 32: RAM read data; valid one cycle after the address was applied.

## Operation
- Instruction word IW fields: op=IW[31:29], i=IW[28], A=IW[27:14], B=IW[13:0].
- `*X` means the memory word at X.
- Operand b is `*B` when i=0 and zero-extended B when i=1.
- Operations (result written to `*A` unless noted; PC advances by 1 unless noted):
  - 0 ADD: `*A` + b, mod 2^32.
  - 1 NAND: ~(`*A` & b).
  - 2 SRL: if b<32, `*A` >> b (logical); else `*A` << (b−32). Shift amounts ≥32 in either direction give 0.
  - 3 LT: 1 if `*A` < b (unsigned), else 0.
  - 4 CP: b.
  - 5 CPI (i=0): `*A` = `*(*B)`.
  - 5 CPIi (i=1): `*(*A)` = `*B`.
  - 6 BZJ (i=0): no write. PC = `*A`[13:0] if `*B`==0, else PC+1.
  - 6 BZJi (i=1): no write. PC = (`*A` + B)[13:0].
  - 7 MUL: low 32 bits of `*A`×b (unsigned).
- Memory addresses taken from data words (CPI, CPIi, BZJ targets) use bits [13:0]. PC wraps modulo 2^14.
- FSM states:
  - FETCH: addr=PC.
  - LD_IW: IW←data_fromRAM; addr=A, taken from data_fromRAM.
  - LD_A: R1←data_fromRAM; addr=B.
  - EXEC: data_fromRAM is `*B`.
    - ALU ops and CP: wrEn=1, addr=A, data=result.
    - CPIi: wrEn=1, addr=R1[13:0], data=`*B`.
    - BZJ/BZJi: update PC, no write.
    - CPI: addr=`*B`[13:0], go to IND.
  - IND (CPI only): wrEn=1, addr=A, data=data_fromRAM.
- All instructions except CPI return from EXEC to FETCH; CPI returns from IND to FETCH. PC updates at the transition to FETCH.
- `*B` is always read, even when i=1; the value is ignored except by CPIi.
- Outputs are combinational from the FSM state, the latches and `data_fromRAM`. `wrEn` is 1 only in write cycles.

## Timing
- Reset asserted (`rst`=0): immediately PC=0, state=FETCH, IW/R1=0.
  - Outputs: wrEn=0, addr_toRAM=0 (=PC), data_toRAM=0.
  - Reset mid-instruction aborts the instruction with no pending write.
- After release, the first rising edge leaves FETCH with addr=0.
- Latency: 4 clocks per instruction (FETCH, LD_IW, LD_A, EXEC); 5 for CPI.
- The write commits at the rising edge that ends the write cycle.
- A write to the location of the next instruction is seen by the following fetch, because fetch comes after the write edge.
- Self-modifying code and `*A` == `*B` aliasing need no special handling; operands are read before the write.

## Test plan
- CP/CPi: mem[0]=0x806401F4, mem[500]=10 → after 4 clocks mem[400]=10. CPi with B=7 → `*A`=7.
- ADD/MUL/LT/NAND/SRL:
  - `*A`=0xFFFFFFFF ADDi B=1 → 0.
  - MUL 6×11 → 66.
  - LT 5<7 → 1; LT 7<5 → 0.
  - NANDi A=0xF0 B=0xFF → 0xFFFFFF0F.
  - SRLi 0x80 by 4 → 0x8.
  - SRLi 1 by 33 → 2.
- CPI/CPIi:
  - `*B`=301, mem[301]=6 → `*A`=6 after 5 clocks.
  - CPIi with `*A`=200, `*B`=9 → mem[200]=9 after 4 clocks.
- BZJ:
  - `*B`=0, `*A`=11 → next fetch addr 11.
  - `*B`=1 → PC+1.
  - BZJi `*A`=3, B=2 → PC=5.
- Reset: assert `rst` low during EXEC of an ADD → no write, wrEn=0 immediately; after release, fetch from address 0.
- wrEn check: wrEn is high only in EXEC/IND cycles of writing instructions, never during BZJ.
